program_rom_sequencer: RTL and testbench
========================================

Name: program_rom_sequencer

Overview:
- Instruction-supply end of the processor's fetch interface: drives `opcode` from an internal loadable program store, indexed by the processor's `program_counter`.
- Owns the program-load handshake from the testbench or host.
- Holds the processor in reset while a program is being loaded.
- Detects the HLT instruction and reports a halted status plus an executed-cycle count.

Parameters:
- ADDR_W, 4, program address width (matches `program_counter`).
- DEPTH, 16, number of program words (2**ADDR_W).
- DATA_W, 8, opcode width.
- NOP_OPCODE, 8'h00, opcode driven whenever not running.
- HLT_OPCODE, 8'hFF, halt instruction.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse: begin loading a program at address 0.
- load_valid  in  1  load data beat valid.
- load_data  in  DATA_W  program word.
- load_last  in  1  qualifies the final beat of a load.
- load_ready  out  1  sequencer accepts a beat this cycle.
- program_counter  in  ADDR_W  fetch address from the processor.
- opcode  out  DATA_W  instruction presented to the processor.
- cpu_reset  out  1  active-high reset to the processor.
- halted  out  1  HLT reached.
- fetch_count  out  16  cycles spent in RUN, saturating.

Behaviour:
- One clock domain (`clk`). `reset_n` is asynchronous and active-low.
- Reset values:
  - state = IDLE, waddr = 0.
  - All DEPTH memory words = NOP_OPCODE.
  - load_ready = 0, cpu_reset = 1, halted = 0, fetch_count = 0, opcode = NOP_OPCODE.
- States: IDLE, LOAD, RUN, HALT.
- Output decode (all decoded from registered state):
  - cpu_reset = 1 in IDLE and LOAD, 0 in RUN and HALT.
  - load_ready = 1 only in LOAD.
  - halted = 1 only in HALT.
- opcode is combinational, with zero-cycle fetch latency:
  - RUN: mem[program_counter].
  - HALT: HLT_OPCODE.
  - IDLE and LOAD: NOP_OPCODE.
- IDLE:
  - load_start -> LOAD, waddr <= 0.
  - All other inputs are ignored.
- LOAD:
  - Beat accepted when load_valid & load_ready: mem[waddr] <= load_data, waddr <= waddr + 1.
  - Accepted beat with load_last = 1, or with waddr == DEPTH-1 -> RUN next cycle.
  - Locations not written in this load keep their previous contents.
  - load_start while in LOAD restarts at waddr = 0; a beat in the same cycle is discarded.
- RUN:
  - fetch_count increments every cycle and saturates at 16'hFFFF.
  - If opcode == HLT_OPCODE at a rising edge -> HALT.
  - load_start -> LOAD (abort): cpu_reset re-asserts the next cycle; fetch_count is held, not cleared.
- HALT:
  - fetch_count is frozen.
  - load_start -> LOAD.
  - program_counter changes are ignored.
- Simultaneous events:
  - load_start has priority over HLT detection and over a data beat.
- fetch_count clears only on reset_n, or on load_start in IDLE or HALT.
- The first RUN cycle presents mem[program_counter], with program_counter = 0 because the processor was in reset.
- Asynchronous reset mid-load or mid-run returns to IDLE immediately; memory is re-cleared to NOP.
- The memory write port is used only in LOAD; the processor's own register writes are unaffected.

Decomposition:
- Shared package `tiny_pkg`:
  - State enum (IDLE/LOAD/RUN/HALT).
  - Opcode constants: NOP_OPCODE, HLT_OPCODE, plus the major-opcode nibbles used by the processor decoder.
  - ADDR_W and DATA_W.
- One natural sub-module, `prog_mem`: DEPTH x DATA_W, async-reset to NOP, one synchronous write port, one combinational read port.
- FSM and counter remain in the top level.

Test Plan:
- Reset then idle:
  - Stimulus: assert reset_n = 0, release, wait 5 cycles.
  - Required: opcode = 8'h00, cpu_reset = 1, load_ready = 0, halted = 0, fetch_count = 0.
- Full load:
  - Stimulus: load_start, then 16 beats of 8'h90..8'h9F with load_valid held high.
  - Required: load_ready high for exactly 16 cycles; RUN on the cycle after the 16th beat; cpu_reset = 0.
  - Required: with program_counter = 5, opcode = 8'h95.
- Short load and halt:
  - Stimulus: load 8'h91, 8'h16, 8'hFF with load_last on the third beat; drive program_counter 0, 1, 2.
  - Required: opcode 8'h91, 8'h16, 8'hFF on those cycles; halted = 1 the next cycle; fetch_count = 3, then frozen.
  - Required: opcode stays 8'hFF while program_counter is held.
- Load backpressure:
  - Stimulus: toggle load_valid 1/0/1 over three words.
  - Required: only cycles with valid = 1 write; waddr advances 0 -> 1 -> 2.
- Abort:
  - Stimulus: in RUN, pulse load_start in the same cycle the fetched opcode is 8'hFF.
  - Required: state = LOAD, not HALT; cpu_reset = 1 next cycle; opcode = 8'h00; a subsequent first beat writes address 0.
- Async reset mid-load:
  - Stimulus: drop reset_n after 2 accepted beats.
  - Required: immediate IDLE, cpu_reset = 1, and mem[0] reads 8'h00 after the next load_start and run.

Source files
------------

// File: rtl/tiny_pkg.sv
// Shared definitions for the tiny processor and its program ROM sequencer:
// address/data widths, special opcodes, major-opcode nibbles used by the
// processor decoder, and the sequencer state encoding.
package tiny_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] NOP_OPCODE = 8'h00;
  localparam logic [DATA_W-1:0] HLT_OPCODE = 8'hFF;

  // Major-opcode nibbles (opcode[7:4]) decoded by the processor.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [15:0] FETCH_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } seq_state_t;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x DATA_W words, asynchronously reset to NOP_OPCODE,
// one synchronous write port and one combinational read port.
// Ports:
//   clk, reset_n      clock / async active-low reset
//   we, waddr, wdata  write port (sampled on rising clk)
//   raddr, rdata      combinational read port
module prog_mem
  import tiny_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every word is reset so a fresh program never executes stale code;
  // this forces flops rather than a RAM macro, which is fine at 16 words.
  // State is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= NOP_OPCODE;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_rom_sequencer.sv
// Instruction-supply end of the processor fetch interface. Loads a program
// over a valid/ready handshake, holds the processor in reset while loading,
// serves opcodes with zero-cycle latency while running, and stops on HLT.
// Ports:
//   clk, reset_n                       clock / async active-low reset
//   load_start                         pulse: (re)start a load at address 0
//   load_valid, load_data, load_last   load beat; load_ready accepts it
//   program_counter                    fetch address from the processor
//   opcode                             instruction presented to the processor
//   cpu_reset                          active-high processor reset
//   halted                             HLT reached
//   fetch_count                        saturating count of RUN cycles
module program_rom_sequencer
  import tiny_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] program_counter,
  output logic [DATA_W-1:0] opcode,
  output logic              cpu_reset,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  seq_state_t        state;
  logic [ADDR_W-1:0] waddr;
  logic [15:0]       fetch_count_q;
  logic [DATA_W-1:0] mem_rdata;
  logic              beat;

  // load_start wins over a beat presented in the same cycle.
  assign beat = (state == LOAD) && load_valid && !load_start;

  prog_mem u_prog_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (beat),
    .waddr   (waddr),
    .wdata   (load_data),
    .raddr   (program_counter),
    .rdata   (mem_rdata)
  );

  // Status outputs decode the registered state, so they are glitch-free.
  assign load_ready  = (state == LOAD);
  assign cpu_reset   = (state == IDLE) || (state == LOAD);
  assign halted      = (state == HALT);
  assign fetch_count = fetch_count_q;

  // NOTE: default first so no path through the case leaves opcode unassigned
  // (which would infer a latch).
  always_comb begin
    opcode = NOP_OPCODE;
    case (state)
      RUN:     opcode = mem_rdata;
      HALT:    opcode = HLT_OPCODE;
      default: opcode = NOP_OPCODE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      waddr         <= '0;
      fetch_count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state         <= LOAD;
            waddr         <= '0;
            fetch_count_q <= '0;
          end
        end
        LOAD: begin
          if (load_start) begin
            waddr <= '0;
          end else if (load_valid) begin
            waddr <= waddr + 1'b1;
            if (load_last || waddr == ADDR_W'(DEPTH - 1)) state <= RUN;
          end
        end
        RUN: begin
          // Every RUN cycle counts, including the one that leaves RUN.
          if (fetch_count_q != FETCH_COUNT_MAX)
            fetch_count_q <= fetch_count_q + 16'd1;
          // An abort keeps the count: it only clears from IDLE or HALT.
          if (load_start) begin
            state <= LOAD;
            waddr <= '0;
          end else if (opcode == HLT_OPCODE) begin
            state <= HALT;
          end
        end
        HALT: begin
          if (load_start) begin
            state         <= LOAD;
            waddr         <= '0;
            fetch_count_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_rom_sequencer.sv
// Self-checking bench for program_rom_sequencer. Inputs are driven just after
// the falling edge and outputs sampled 1 ns later, well away from the rising
// edge. Expected opcodes come from a bench-side program model and flow
// through a scoreboard queue.
module tb_program_rom_sequencer;

  logic        clk;
  logic        reset_n;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic [3:0]  program_counter;
  logic [7:0]  opcode;
  logic        cpu_reset;
  logic        halted;
  logic [15:0] fetch_count;

  int          vectors;
  int          miscompares;
  logic [7:0]  tb_mem [16];
  logic [7:0]  exp_q  [$];
  logic [7:0]  prog_q [$];
  logic [7:0]  exp_op;

  program_rom_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .load_start      (load_start),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_last       (load_last),
    .load_ready      (load_ready),
    .program_counter (program_counter),
    .opcode          (opcode),
    .cpu_reset       (cpu_reset),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n         = 1'b0;
    load_start      = 1'b0;
    load_valid      = 1'b0;
    load_data       = 8'h00;
    load_last       = 1'b0;
    program_counter = 4'd0;
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse load_start, then stream prog_q with load_last on the final word.
  // Returns at the falling edge where the sequencer is already in RUN.
  task automatic load_words();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      load_valid = 1'b1;
      load_data  = prog_q[i];
      load_last  = (i == prog_q.size() - 1);
      tb_mem[i]  = prog_q[i];
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    vectors++; if (opcode !== 8'h00) begin miscompares++; $display("FAIL reset_opcode got %h exp %h", opcode, 8'h00); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
    vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_load_ready got %b exp 0", load_ready); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b exp 0", halted); end
    vectors++; if (fetch_count !== 16'd0) begin miscompares++; $display("FAIL reset_fetch_count got %0d exp 0", fetch_count); end
  endtask

  task automatic test_full_load();
    int ready_cycles;
    do_reset();
    load_start = 1'b1;
    @(negedge clk);
    load_start   = 1'b0;
    ready_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!load_ready) break;
      ready_cycles++;
      load_valid = 1'b1;
      load_data  = 8'h90 + 8'(c);
      tb_mem[c % 16] = 8'h90 + 8'(c);
      @(negedge clk);
    end
    load_valid = 1'b0;
    vectors++; if (ready_cycles != 16) begin miscompares++; $display("FAIL full_load_ready_cycles got %0d exp 16", ready_cycles); end
    vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("FAIL full_load_cpu_reset got %b exp 0", cpu_reset); end
    program_counter = 4'd5;
    exp_q.push_back(tb_mem[5]);
    #1;
    exp_op = exp_q.pop_front();
    vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL full_load_pc5 got %h exp %h", opcode, exp_op); end
  endtask

  task automatic test_short_load_halt();
    do_reset();
    prog_q = '{8'h91, 8'h16, 8'hFF};
    load_words();
    for (int pc = 0; pc < 3; pc++) begin
      program_counter = 4'(pc);
      exp_q.push_back(tb_mem[pc]);
      #1;
      exp_op = exp_q.pop_front();
      vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL short_opcode_pc%0d got %h exp %h", pc, opcode, exp_op); end
      vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL short_halted_early_pc%0d got %b exp 0", pc, halted); end
      @(negedge clk);
    end
    #1;
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL short_halted got %b exp 1", halted); end
    vectors++; if (fetch_count !== 16'd3) begin miscompares++; $display("FAIL short_fetch_count got %0d exp 3", fetch_count); end
    // Held PC, then a PC change: HALT keeps presenting HLT and the count frozen.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) program_counter = 4'd0;
      exp_q.push_back(8'hFF);
      #1;
      exp_op = exp_q.pop_front();
      vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL halt_opcode_%0d got %h exp %h", k, opcode, exp_op); end
      vectors++; if (fetch_count !== 16'd3) begin miscompares++; $display("FAIL halt_fetch_frozen_%0d got %0d exp 3", k, fetch_count); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] data_seq [4];
    logic       valid_seq [4];
    int         wa;
    data_seq  = '{8'hA0, 8'hEE, 8'hA1, 8'hA2};
    valid_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    wa = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid = valid_seq[i];
      load_data  = data_seq[i];
      // load_last during the idle gap must not end the load.
      load_last  = (i == 1) || (i == 3);
      if (valid_seq[i]) begin
        tb_mem[wa] = data_seq[i];
        wa++;
      end
      @(negedge clk);
      if (i == 1) begin
        #1;
        vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL bp_still_loading got %b exp 1", load_ready); end
      end
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int pc = 0; pc < 4; pc++) begin
      program_counter = 4'(pc);
      exp_q.push_back(tb_mem[pc]);
      #1;
      exp_op = exp_q.pop_front();
      vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL bp_opcode_pc%0d got %h exp %h", pc, opcode, exp_op); end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    do_reset();
    prog_q = '{8'h20, 8'hFF};
    load_words();
    program_counter = 4'd0;
    exp_q.push_back(tb_mem[0]);
    #1;
    exp_op = exp_q.pop_front();
    vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL abort_pc0 got %h exp %h", opcode, exp_op); end
    @(negedge clk);
    program_counter = 4'd1;
    load_start      = 1'b1;
    exp_q.push_back(tb_mem[1]);
    #1;
    exp_op = exp_q.pop_front();
    vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL abort_pc1 got %h exp %h", opcode, exp_op); end
    @(negedge clk);
    load_start = 1'b0;
    #1;
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL abort_not_halted got %b exp 0", halted); end
    vectors++; if (load_ready !== 1'b1) begin miscompares++; $display("FAIL abort_in_load got %b exp 1", load_ready); end
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL abort_cpu_reset got %b exp 1", cpu_reset); end
    vectors++; if (opcode !== 8'h00) begin miscompares++; $display("FAIL abort_opcode got %h exp %h", opcode, 8'h00); end
    vectors++; if (fetch_count === 16'd0) begin miscompares++; $display("FAIL abort_fetch_kept got %0d exp nonzero", fetch_count); end
    // One beat after the abort lands at address 0; address 1 keeps HLT.
    load_valid = 1'b1;
    load_data  = 8'h33;
    load_last  = 1'b1;
    tb_mem[0]  = 8'h33;
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
    for (int pc = 0; pc < 2; pc++) begin
      program_counter = 4'(pc);
      exp_q.push_back(tb_mem[pc]);
      #1;
      exp_op = exp_q.pop_front();
      vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL abort_reload_pc%0d got %h exp %h", pc, opcode, exp_op); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'h55;
    @(negedge clk);
    load_data  = 8'h66;
    @(negedge clk);
    load_data  = 8'h77;
    #1;
    reset_n = 1'b0;
    #1;
    vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL async_cpu_reset got %b exp 1", cpu_reset); end
    vectors++; if (load_ready !== 1'b0) begin miscompares++; $display("FAIL async_load_ready got %b exp 0", load_ready); end
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;
    @(negedge clk);
    reset_n    = 1'b1;
    load_valid = 1'b0;
    @(negedge clk);
    // Reload one word at address 0; address 1 previously held 8'h66 and must
    // read as cleared NOP.
    prog_q = '{8'h77};
    load_words();
    for (int pc = 0; pc < 3; pc++) begin
      program_counter = 4'(pc);
      exp_q.push_back(tb_mem[pc]);
      #1;
      exp_op = exp_q.pop_front();
      vectors++; if (opcode !== exp_op) begin miscompares++; $display("FAIL async_opcode_pc%0d got %h exp %h", pc, opcode, exp_op); end
      @(negedge clk);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    reset_n         = 1'b0;
    load_start      = 1'b0;
    load_valid      = 1'b0;
    load_data       = 8'h00;
    load_last       = 1'b0;
    program_counter = 4'd0;
    for (int i = 0; i < 16; i++) tb_mem[i] = 8'h00;

    test_reset();
    test_full_load();
    test_short_load_halt();
    test_backpressure();
    test_abort();
    test_async_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
